nn_mac_neuron: RTL and testbench

//  Downstream consumer of the wishbone_nn input FIFO. Pops 32-bit words on a

---
 rtl/nn_mac_neuron.sv | 171 +++++++++++++++++
 tb/tb_nn_mac_neuron.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mac_neuron.sv
// -----------------------------------------------------------------------------
// nn_mac_neuron
//
// Fixed-point neuron that drains the wishbone_nn input FIFO. Each group is one
// signed Q16.16 bias word followed by N_INPUTS pair words, each holding a Q8.8
// weight [31:16] and a Q8.8 activation [15:0]. The Q16.16 products are summed
// onto the bias. The sum is rescaled to Q8.8 with optional ReLU and
// saturation, then offered as one result on a valid/ready output stream.
//
// Parameters
//   N_INPUTS  weight/activation pairs per neuron (1 .. 2^(ACC_W-32))
//   ACC_W     signed accumulator width (>= 33)
//   RELU      1: negative results become 0, 0: signed result passes through
//
// Ports
//   wb_clk_i   in   1   clock, rising edge
//   wb_rst_i   in   1   asynchronous active-high reset
//   in_valid   in   1   FIFO head word available
//   in_data    in   32  FIFO head word
//   in_ready   out  1   pop strobe, word consumed when in_valid & in_ready
//   out_valid  out  1   result available
//   out_data   out  16  signed Q8.8 result
//   out_sat    out  1   result was saturated (qualified by out_valid)
//   out_ready  in   1   consumer takes the result when out_valid & out_ready
//   busy       out  1   a group is in progress (any state but S_BIAS)
// -----------------------------------------------------------------------------
module nn_mac_neuron #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 40,
    parameter bit RELU     = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_sat,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_BIAS,
        S_MAC,
        S_ACT,
        S_OUT
    } state_t;

    localparam int                    CNT_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] Q_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] Q_MIN  = -Q_MAX - 1;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [15:0]               out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic signed [15:0]        weight;
    logic signed [15:0]        activ;
    logic signed [31:0]        product;
    logic signed [ACC_W-1:0]   scaled;
    logic                      accept;

    // Q8.8 * Q8.8 gives a full-precision Q16.16 product. This matches the bias
    // format, so products add onto the bias without realignment.
    assign weight  = in_data[31:16];
    assign activ   = in_data[15:0];
    assign product = weight * activ;

    // Q16.16 -> Q8.8: an arithmetic shift floors toward minus infinity.
    assign scaled  = acc_q >>> 8;

    assign accept  = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        in_ready    = 1'b0;

        case (state_q)
            S_BIAS: begin
                in_ready = !wb_rst_i;
                if (accept) begin
                    acc_d   = ACC_W'($signed(in_data));
                    cnt_d   = '0;
                    state_d = S_MAC;
                end
            end

            S_MAC: begin
                in_ready = !wb_rst_i;
                if (accept) begin
                    acc_d = acc_q + ACC_W'(product);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_ACT;
                    end
                end
            end

            S_ACT: begin
                if (RELU && scaled < 0) begin
                    out_data_d = 16'h0000;
                    out_sat_d  = 1'b0;
                end else if (scaled > Q_MAX) begin
                    out_data_d = 16'h7FFF;
                    out_sat_d  = 1'b1;
                end else if (scaled < Q_MIN) begin
                    out_data_d = 16'h8000;
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = scaled[15:0];
                    out_sat_d  = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end

            S_OUT: begin
                // Result is held until taken. Clearing acc here means the next
                // group cannot pick up any residue.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    state_d     = S_BIAS;
                end
            end

            default: begin
                state_d = S_BIAS;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_BIAS;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop updates from the
            // values that existed before the edge.
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = (state_q != S_BIAS);

endmodule

// File: tb/tb_nn_mac_neuron.sv
// -----------------------------------------------------------------------------
// tb_nn_mac_neuron
//
// Two neurons, one with ReLU and one without, share a single input and output
// handshake stream. Their timing is identical, so one driver feeds both. A
// reference model pushes the expected result for each group into a queue per
// instance, and a monitor pops and compares whenever a result is taken.
// -----------------------------------------------------------------------------
module tb_nn_mac_neuron;

    typedef logic [31:0] pairs_t [4];

    typedef struct {
        logic [15:0] data;
        logic        sat;
        string       tag;
    } exp_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data  = '0;
    logic        out_ready = 1'b1;

    logic        in_ready_r, out_valid_r, out_sat_r, busy_r;
    logic [15:0] out_data_r;
    logic        in_ready_l, out_valid_l, out_sat_l, busy_l;
    logic [15:0] out_data_l;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_r[$];
    exp_t exp_l[$];
    time  pop_times[$];
    exp_t e_r, e_l;

    always #5 wb_clk_i = ~wb_clk_i;

    nn_mac_neuron #(.N_INPUTS(4), .ACC_W(40), .RELU(1'b1)) dut_relu (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready_r),
        .out_valid(out_valid_r),
        .out_data (out_data_r),
        .out_sat  (out_sat_r),
        .out_ready(out_ready),
        .busy     (busy_r)
    );

    nn_mac_neuron #(.N_INPUTS(4), .ACC_W(40), .RELU(1'b0)) dut_lin (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready_l),
        .out_valid(out_valid_l),
        .out_data (out_data_l),
        .out_sat  (out_sat_l),
        .out_ready(out_ready),
        .busy     (busy_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: 64-bit accumulation, then floor-shift, ReLU and saturation.
    function automatic exp_t model(input logic [31:0] bias, input pairs_t p,
                                   input bit relu, input string tag);
        exp_t               e;
        longint             acc;
        longint             r;
        logic signed [15:0] w, x;
        acc = longint'($signed(bias));
        for (int i = 0; i < 4; i++) begin
            w   = p[i][31:16];
            x   = p[i][15:0];
            acc = acc + longint'(w) * longint'(x);
        end
        r     = acc >>> 8;
        e.tag = tag;
        if (relu && r < 0) begin
            e.data = 16'h0000; e.sat = 1'b0;
        end else if (r > 32767) begin
            e.data = 16'h7FFF; e.sat = 1'b1;
        end else if (r < -32768) begin
            e.data = 16'h8000; e.sat = 1'b1;
        end else begin
            e.data = r[15:0];  e.sat = 1'b0;
        end
        return e;
    endfunction

    // Offer one word and return #1 after the edge that consumes it.
    task automatic send_word(input logic [31:0] w);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge wb_clk_i);
            if (in_ready_r) begin
                @(posedge wb_clk_i);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    // gap_mode: 0 none, 1 one idle cycle before each pair, 2 random 0..2 idles
    task automatic send_group(input logic [31:0] bias, input pairs_t p,
                              input int gap_mode, input string tag);
        exp_r.push_back(model(bias, p, 1'b1, {tag, "_relu"}));
        exp_l.push_back(model(bias, p, 1'b0, {tag, "_lin"}));
        send_word(bias);
        for (int i = 0; i < 4; i++) begin
            if (gap_mode == 1) idle_cycles(1);
            else if (gap_mode == 2) idle_cycles($urandom_range(0, 2));
            send_word(p[i]);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_r.size() != 0 || exp_l.size() != 0) && t < 200) begin
            @(posedge wb_clk_i);
            #1;
            t++;
        end
        check({tag, "_drain"}, exp_r.size() + exp_l.size(), 32'd0);
    endtask

    // Scoreboard monitor: a result is taken on the edge after this sample.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && out_ready) begin
            if (out_valid_r) begin
                pop_times.push_back($time);
                if (exp_r.size() == 0) begin
                    check("relu_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e_r = exp_r.pop_front();
                    check({e_r.tag, "_data"}, out_data_r, e_r.data);
                    check({e_r.tag, "_sat"},  out_sat_r,  e_r.sat);
                end
            end
            if (out_valid_l) begin
                if (exp_l.size() == 0) begin
                    check("lin_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e_l = exp_l.pop_front();
                    check({e_l.tag, "_data"}, out_data_l, e_l.data);
                    check({e_l.tag, "_sat"},  out_sat_l,  e_l.sat);
                end
            end
        end
    end

    initial begin
        pairs_t p_one, p_neg, p_max, p_min, p_rnd;
        bit     seen;
        time    dt;

        foreach (p_one[i]) p_one[i] = 32'h01000200;
        foreach (p_neg[i]) p_neg[i] = 32'hFF000200;
        foreach (p_max[i]) p_max[i] = 32'h7FFF7FFF;
        foreach (p_min[i]) p_min[i] = 32'h80007FFF;

        // Reset state
        #2 wb_rst_i = 1'b1;
        idle_cycles(2);
        check("rst_out_valid", out_valid_r, 32'd0);
        check("rst_out_data",  out_data_r,  32'h0);
        check("rst_out_sat",   out_sat_l,   32'd0);
        check("rst_busy",      busy_r,      32'd0);
        check("rst_in_ready",  in_ready_r,  32'd0);
        check("rst_in_ready_l", in_ready_l, 32'd0);
        wb_rst_i = 1'b0;
        #1;
        check("idle_in_ready", in_ready_r, 32'd1);

        // Case 1: basic group, with a latency check
        send_group(32'h00000000, p_one, 0, "c1");
        check("c1_lat_k",   out_valid_r, 32'd0);
        check("c1_busy",    busy_r,      32'd1);
        idle_cycles(1);
        check("c1_lat_k1",  out_valid_r, 32'd1);
        check("c1_lat_k1_l", out_valid_l, 32'd1);
        drain("c1");

        // Case 2: bias contribution, then a negative sum with and without ReLU
        send_group(32'h00010000, p_one, 0, "c2_bias");
        send_group(32'h00000000, p_neg, 0, "c2_neg");
        drain("c2");

        // Case 3: positive and negative saturation
        send_group(32'h00000000, p_max, 0, "c3_max");
        send_group(32'h00000000, p_min, 0, "c3_min");
        drain("c3");

        // Case 4: in_valid gaps, then back-pressure on the result
        out_ready = 1'b0;
        send_group(32'h00000000, p_one, 1, "c4");
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge wb_clk_i);
            seen = out_valid_r;
        end
        check("c4_out_valid_seen", seen, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            check("c4_hold_valid",    out_valid_r, 32'd1);
            check("c4_hold_data",     out_data_r,  32'h0800);
            check("c4_hold_in_ready", in_ready_r,  32'd0);
        end
        @(posedge wb_clk_i);
        #1 out_ready = 1'b1;
        drain("c4");

        // Case 5: reset in mid-group discards the partial sum
        send_word(32'h00000000);
        send_word(32'h01000200);
        send_word(32'h01000200);
        check("c5_busy_before", busy_r, 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check("c5_busy_rst",      busy_r,      32'd0);
        check("c5_out_valid_rst", out_valid_r, 32'd0);
        check("c5_in_ready_rst",  in_ready_r,  32'd0);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        send_group(32'h00000000, p_one, 0, "c5_after");
        drain("c5");

        // Case 6: back-to-back groups, results 7 cycles apart
        pop_times.delete();
        send_group(32'h00010000, p_one, 0, "c6_a");
        send_group(32'h00000000, p_neg, 0, "c6_b");
        drain("c6");
        if (pop_times.size() == 2) dt = (pop_times[1] - pop_times[0]) / 10;
        else dt = 0;
        check("c6_spacing", 32'(dt), 32'd7);

        // Random groups with random gaps
        for (int g = 0; g < 8; g++) begin
            foreach (p_rnd[i]) p_rnd[i] = $urandom;
            send_group($urandom, p_rnd, 2, $sformatf("rnd%0d", g));
        end
        drain("rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
